// File: rtl/sdm_audio_out_pkg.sv
// sdm_audio_out_pkg: shared widths, mid-scale value, FSM states and LFSR constants
`timescale 1ns/1ps
package sdm_audio_out_pkg;
    localparam int SAMPLE_W = 18;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 18'h20000;
    typedef enum logic [1:0] {IDLE, RUN, UNDERRUN} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/sdm_audio_out_mod1.sv
// sdm_mod1: first-order sigma-delta accumulator; SDM_DITHER_EN adds LFSR dither on its input
`timescale 1ns/1ps
module sdm_mod1
    import sdm_audio_out_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W:0]   acc_q, acc_d;
    logic [W-1:0] mod_in;
`ifdef SDM_DITHER_EN
    localparam logic [W+1:0] MAXV = {2'b00, {W{1'b1}}};
    logic [15:0]  lfsr_q, lfsr_d;
    logic [W+1:0] dith, dith_m;
    // din + lfsr[3:0] - 8, clamped back into the unsigned sample range
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        dith   = {2'b00, din} + (W+2)'(lfsr_q[3:0]);
        dith_m = dith - (W+2)'(8);
        mod_in = (dith < (W+2)'(8)) ? '0 : (dith_m > MAXV) ? '1 : dith_m[W-1:0];
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= lfsr_d;
`else
    always_comb mod_in = din;
`endif
    always_comb acc_d = {1'b0, acc_q[W-1:0]} + {1'b0, mod_in};
    always_ff @(posedge clk or negedge rst)
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    assign dout = acc_q[W];
endmodule

// File: rtl/sdm_audio_out.sv
// sdm_audio_out: one-sample buffer, sample-rate divider, underrun FSM and 1-bit sigma-delta DAC.
// Define SDM_DITHER_EN to add LFSR dither ahead of the modulator.
`timescale 1ns/1ps
module sdm_audio_out #(
    parameter int SAMPLE_W = 18,
    parameter int TICK_DIV = 1024,
    parameter int UCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sample_tick,
    output logic                dac_out,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_count
);
    import sdm_audio_out_pkg::*;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MIDSCALE);
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic [SAMPLE_W-1:0] buf_q, buf_d, active_q, active_d;
    logic                full_q, full_d;
    logic [UCNT_W-1:0]   ucnt_q, ucnt_d;
    logic                accept;
    state_t              state_q, state_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            div_q    <= '0;
            tick_q   <= 1'b0;
            buf_q    <= '0;
            full_q   <= 1'b0;
            active_q <= MID;
            ucnt_q   <= '0;
            state_q  <= IDLE;
        end else begin
            div_q    <= div_d;
            tick_q   <= tick_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            active_q <= active_d;
            ucnt_q   <= ucnt_d;
            state_q  <= state_d;
        end
    // The tick sees the buffer as it was before any same-cycle accept
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d   = (div_q == DIV_LAST);
        accept   = sample_valid && !full_q;
        state_d  = state_q;
        active_d = active_q;
        ucnt_d   = ucnt_q;
        full_d   = full_q;
        buf_d    = buf_q;
        if (tick_q) begin
            if (full_q) begin
                state_d  = RUN;
                active_d = buf_q;
                full_d   = 1'b0;
            end else if (state_q != IDLE) begin
                state_d = UNDERRUN;
                ucnt_d  = (&ucnt_q) ? ucnt_q : ucnt_q + 1'b1;
            end
        end
        if (accept) begin
            buf_d  = sample_in;
            full_d = 1'b1;
        end
    end
    sdm_mod1 #(.W(SAMPLE_W)) u_mod (
        .clk  (clk),
        .rst  (rst),
        .din  (active_q),
        .dout (dac_out)
    );
    assign sample_ready   = !full_q;
    assign sample_tick    = tick_q;
    assign underrun       = (state_q == UNDERRUN);
    assign underrun_count = ucnt_q;
endmodule

// File: doc/sdm_audio_out.md
Name: sdm_audio_out

Overview:
- Output stage directly downstream of the two-voice mixer.
- Accepts 18-bit unsigned, mid-scale-offset samples (0x20000 = silence) over a valid/ready handshake and buffers one sample.
- Releases samples at a fixed sample-rate tick.
- Converts the active sample to a 1-bit pulse-density stream with a first-order sigma-delta modulator, for an RC-filtered FPGA pin.

Parameters:
- SAMPLE_W, 18, sample width in bits; the mixer output width.
- TICK_DIV, 1024, clk cycles per sample period; must be ≥ 4.
- UCNT_W, 8, width of the saturating underrun counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- sample_in  in  SAMPLE_W  unsigned sample from the mixer.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  one-entry buffer can accept.
- sample_tick  out  1  one-cycle pulse at each sample-period boundary; upstream uses it to advance the mixer pipeline.
- dac_out  out  1  pulse-density output bit.
- underrun  out  1  high while the FSM is in UNDERRUN.
- underrun_count  out  UCNT_W  saturating count of ticks that found the buffer empty.

Behaviour:
- Reset, applied asynchronously while rst=0:
  - dac_out=0, sample_tick=0, underrun=0, underrun_count=0, sample_ready=1.
  - Divider=0, accumulator=0, buffer empty, active sample=0x20000, FSM=IDLE.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps.
  - sample_tick is registered: high for exactly one cycle when the divider equals TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset release.
- Buffer:
  - sample_ready = !buf_full, driven from a register with no combinational path from sample_valid.
  - Accept when sample_valid && sample_ready: buf <= sample_in, buf_full <= 1.
  - On a tick with buf_full: active <= buf, buf_full <= 0, so sample_ready rises the cycle after the tick.
  - Accept and tick in the same cycle with the buffer empty: the tick sees empty, and the sample lands in buf for the next tick.
- FSM, evaluated only on tick cycles:
  - IDLE: buf_full → RUN (load active); empty → stay in IDLE, active stays 0x20000, no count.
  - RUN: buf_full → RUN (load active); empty → UNDERRUN, underrun_count+1.
  - UNDERRUN: buf_full → RUN (load active); empty → stay, underrun_count+1.
  - Active sample is held unchanged through UNDERRUN.
  - underrun_count saturates at all-ones and is cleared only by reset.
- Modulator (runs every cycle, independent of ticks):
  - acc is SAMPLE_W+1 bits: acc <= {1'b0, acc[SAMPLE_W-1:0]} + active.
  - dac_out <= acc carry bit (acc[SAMPLE_W]), registered.
  - Ones density = active / 2^SAMPLE_W.
  - The new active value takes effect the cycle after the tick.
- Reset asserted mid-period: all state returns to reset values immediately; a pending buffered sample is discarded.

Optional Feature:
- Macro: SDM_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) steps every cycle.
  - Modulator input = active + lfsr[3:0] - 8, saturated to [0, 2^SAMPLE_W-1], to break idle tones.
  - Long-run density is unchanged within ±1 LSB.
- Undefined: no LFSR, and modulator input = active exactly.

Decomposition:
- Shared package holds:
  - SAMPLE_W=18 and MIDSCALE=18'h20000.
  - FSM state enum {IDLE, RUN, UNDERRUN}, 2 bits.
  - The LFSR seed and tap constants.
- One sub-module, sdm_mod1:
  - Contains the accumulator plus the optional dither.
  - Ports: clk, rst, din[SAMPLE_W-1:0], dout.
- The divider, buffer and FSM stay in sdm_audio_out.

Test Plan:
- Reset, then no samples: sample_ready=1; underrun=0 for ≥3 ticks with underrun_count=0; dac_out ones over any aligned 1024-cycle window = 512.
- Push 0x30000 before tick 1: sample_ready falls the cycle after acceptance and rises the cycle after tick; the 1024 cycles following the tick contain 768±1 ones.
- Push 0x00000 → zero ones in the next period; push 0x3FFFF → ≥1023 ones in the next period.
- Present two samples back-to-back before a tick: only the first is accepted (sample_ready=0 on the second); the second is accepted the cycle after the tick and becomes active at the following tick.
- In RUN, skip one period: at that tick underrun=1 and underrun_count=1, and density stays at the previous value; the next supplied sample returns the FSM to RUN at the following tick. Forcing 300 empty ticks leaves underrun_count=255.
- Drop rst for 3 ns mid-period between clk edges: dac_out=0, sample_tick=0 and sample_ready=1 immediately; the buffered sample is lost; the first tick occurs TICK_DIV cycles after release.
